iomem_axis_bridge: RTL and testbench

- Memory-mapped responder on the PicoSoC iomem bus; the SoC CPU is the initiator.
- Bridges CPU load/store to a pair of AXI-Stream byte channels, each with an internal FIFO. A TX byte stream leaves toward a serialiser; an RX byte stream arrives from a deserialiser.
- Provides status/control registers and a level-sensitive interrupt intended for irq_5/6/7.

---
 rtl/iomem_axis_bridge_pkg.sv | 39 +++
 rtl/iomem_axis_bridge_fifo.sv | 66 ++++++
 rtl/iomem_axis_bridge.sv | 138 +++++++++++++
 tb/tb_iomem_axis_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_axis_bridge_pkg.sv
// Shared constants and helpers for the iomem-to-AXI-Stream bridge.
package iomem_axis_bridge_pkg;

    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_TX_FULL     = 1;
    localparam int unsigned ST_RX_OVERFLOW = 2;
    localparam int unsigned ST_TX_EMPTY    = 3;

    localparam int unsigned CTRL_RX_IRQ_EN  = 0;
    localparam int unsigned CTRL_TXE_IRQ_EN = 1;
    localparam int unsigned CTRL_BITS       = 2;

    localparam logic [31:0] EMPTY_READ_VALUE = 32'hFFFF_FFFF;

    // Assemble the STATUS word: flags in [3:0], rx level in [15:8], tx level in [23:16].
    function automatic logic [31:0] pack_status(
        input logic       rx_nonempty,
        input logic       tx_full,
        input logic       rx_overflow,
        input logic       tx_empty,
        input logic [7:0] rx_level,
        input logic [7:0] tx_level
    );
        logic [31:0] word;
        word                 = '0;
        word[ST_RX_NONEMPTY] = rx_nonempty;
        word[ST_TX_FULL]     = tx_full;
        word[ST_RX_OVERFLOW] = rx_overflow;
        word[ST_TX_EMPTY]    = tx_empty;
        word[15:8]           = rx_level;
        word[23:16]          = tx_level;
        return word;
    endfunction

endpackage

// File: rtl/iomem_axis_bridge_fifo.sv
// Synchronous valid/ready FIFO with a registered fill level.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module axis_fifo_sync #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready_c,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid_c,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data_c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    always_comb begin
        full        = (level == LW'(DEPTH));
        empty       = (level == '0);
        pop         = out_ready && !empty;
        push        = in_valid && (!full || pop);
        in_ready_c  = !full;
        out_valid_c = !empty;
        out_data_c  = mem[rd_ptr];
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/iomem_axis_bridge.sv
// PicoSoC iomem responder bridging CPU loads/stores to TX/RX AXI-Stream byte FIFOs,
// with STATUS/CTRL registers and a level interrupt.
module iomem_axis_bridge
    import iomem_axis_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iomem_valid,
    output logic                 iomem_ready,
    input  logic [3:0]           iomem_wstrb,
    input  logic [31:0]          iomem_addr,
    input  logic [31:0]          iomem_wdata,
    output logic [31:0]          iomem_rdata,
    output logic                 irq,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [DATA_BITS-1:0] s_axis_tdata
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [LW-1:0]        tx_level;
    logic [LW-1:0]        rx_level;
    logic                 tx_in_ready;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_push;

    logic [CTRL_BITS-1:0] ctrl;
    logic                 rx_overflow;

    logic                 sel;
    logic [7:0]           off;
    logic                 is_write;
    logic                 take;
    logic                 stall;
    logic                 accept;
    logic                 tx_push_req;
    logic                 tx_pop;
    logic                 rx_pop;
    logic                 ctrl_write;
    logic                 ovf_clear;
    logic [31:0]          rdata_next;
    logic                 unused_wdata;

    assign unused_wdata = ^iomem_wdata;

    axis_fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (tx_push_req),
        .in_ready_c  (tx_in_ready),
        .in_data     (iomem_wdata[DATA_BITS-1:0]),
        .out_valid_c (m_axis_tvalid),
        .out_ready   (m_axis_tready),
        .out_data_c  (m_axis_tdata),
        .level       (tx_level)
    );

    axis_fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (rx_push),
        .in_ready_c  (s_axis_tready),
        .in_data     (s_axis_tdata),
        .out_valid_c (rx_valid),
        .out_ready   (rx_pop),
        .out_data_c  (rx_data),
        .level       (rx_level)
    );

    // Decode the CPU request; a full-TX DATA write stalls unless a TX pop frees a slot now.
    always_comb begin
        sel         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
        off         = iomem_addr[7:0];
        is_write    = |iomem_wstrb;
        take        = sel && !iomem_ready;
        tx_pop      = m_axis_tvalid && m_axis_tready;
        tx_push_req = take && (off == REG_DATA) && iomem_wstrb[0];
        stall       = tx_push_req && !tx_in_ready && !tx_pop;
        accept      = take && !stall;
        rx_pop      = take && (off == REG_DATA) && !is_write && rx_valid;
        rx_push     = s_axis_tvalid && s_axis_tready;
        ctrl_write  = take && (off == REG_CTRL) && iomem_wstrb[0];
        ovf_clear   = take && (off == REG_STATUS) && iomem_wstrb[0]
                      && iomem_wdata[ST_RX_OVERFLOW];

        rdata_next = '0;
        if (!is_write) begin
            case (off)
                REG_DATA:   rdata_next = rx_valid ? 32'(rx_data) : EMPTY_READ_VALUE;
                REG_STATUS: rdata_next = pack_status(rx_valid, !tx_in_ready, rx_overflow,
                                                     !m_axis_tvalid, 8'(rx_level), 8'(tx_level));
                REG_CTRL:   rdata_next = 32'(ctrl);
                default:    rdata_next = '0;
            endcase
        end
    end

    // Completion, register state and interrupt; a fresh overflow wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
            ctrl        <= '0;
            rx_overflow <= 1'b0;
        end else begin
            iomem_ready <= accept;
            iomem_rdata <= accept ? rdata_next : '0;
            if (ctrl_write) begin
                ctrl <= iomem_wdata[CTRL_BITS-1:0];
            end
            if (ovf_clear) begin
                rx_overflow <= 1'b0;
            end
            if (s_axis_tvalid && !s_axis_tready) begin
                rx_overflow <= 1'b1;
            end
            irq <= (ctrl[CTRL_RX_IRQ_EN] && rx_valid)
                   || (ctrl[CTRL_TXE_IRQ_EN] && !m_axis_tvalid);
        end
    end

endmodule

// File: tb/tb_iomem_axis_bridge.sv
// Directed scoreboard bench for iomem_axis_bridge.
module tb_iomem_axis_bridge;
    import iomem_axis_bridge_pkg::*;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    iomem_axis_bridge #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (16),
        .DATA_BITS  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .iomem_valid   (iomem_valid),
        .iomem_ready   (iomem_ready),
        .iomem_wstrb   (iomem_wstrb),
        .iomem_addr    (iomem_addr),
        .iomem_wdata   (iomem_wdata),
        .iomem_rdata   (iomem_rdata),
        .irq           (irq),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access: expects a 1-cycle ack, then idles one cycle so ready returns low.
    task automatic cpu_xfer(input string tag, input logic [7:0] off, input logic [3:0] strb,
                            input logic [31:0] wd, input bit chk, input logic [31:0] exp);
        int n;
        n           = 0;
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'(off);
        iomem_wstrb = strb;
        iomem_wdata = wd;
        do begin
            tick();
            n++;
        end while (!iomem_ready && n < 50);
        check({tag, " latency"}, 32'(n), 32'd1);
        if (chk) begin
            check({tag, " rdata"}, iomem_rdata, exp);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick();
    endtask

    task automatic cpu_write(input string tag, input logic [7:0] off, input logic [31:0] wd);
        cpu_xfer(tag, off, 4'h1, wd, 1'b0, 32'h0);
    endtask

    task automatic status_read(input string tag, input logic [31:0] exp);
        cpu_xfer(tag, REG_STATUS, 4'h0, 32'h0, 1'b1, exp);
    endtask

    task automatic data_read(input string tag);
        logic [31:0] exp;
        exp = (rxq.size() > 0) ? 32'(rxq.pop_front()) : EMPTY_READ_VALUE;
        cpu_xfer(tag, REG_DATA, 4'h0, 32'h0, 1'b1, exp);
    endtask

    // TX monitor: the byte presented when a handshake is about to occur must match the scoreboard.
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            checks++;
            assert (txq.size() != 0) else begin
                errors++;
                $error("FAIL tx unexpected byte: observed=%h expected=none", m_axis_tdata);
            end
            if (txq.size() != 0) begin
                check("tx byte", 32'(m_axis_tdata), 32'(txq.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        iomem_valid   = 1'b0;
        iomem_wstrb   = 4'h0;
        iomem_addr    = 32'h0;
        iomem_wdata   = 32'h0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        tick();
        tick();
        check("reset ready", 32'(iomem_ready), 32'd0);
        check("reset rdata", iomem_rdata, 32'h0);
        check("reset irq", 32'(irq), 32'd0);
        check("reset m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset s_tready", 32'(s_axis_tready), 32'd1);
        reset = 1'b0;
        tick();

        // Single TX byte passes straight through.
        m_axis_tready = 1'b1;
        txq.push_back(8'h41);
        cpu_write("tx 0x41", REG_DATA, 32'h0000_0041);
        check("tx single drained", 32'(txq.size()), 32'd0);
        status_read("status after single tx", 32'h0000_0008);

        // Fill TX with backpressure, then a 17th write stalls.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            txq.push_back(8'(i));
            cpu_write("tx fill", REG_DATA, 32'(i));
        end
        txq.push_back(8'h10);
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'(REG_DATA);
        iomem_wstrb = 4'h1;
        iomem_wdata = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tx stall ready low", 32'(iomem_ready), 32'd0);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        check("tx stall released", 32'(iomem_ready), 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick();
        status_read("status tx full", 32'h0010_0002);
        m_axis_tready = 1'b1;
        repeat (20) tick();
        check("tx fill drained", 32'(txq.size()), 32'd0);
        check("tx empty tvalid", 32'(m_axis_tvalid), 32'd0);

        // Three RX bytes, read back in order, then an empty read.
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = 8'(8'h10 + i);
            rxq.push_back(s_axis_tdata);
            tick();
        end
        s_axis_tvalid = 1'b0;
        status_read("status rx 3", 32'h0000_0309);
        for (int i = 0; i < 4; i++) begin
            data_read("rx data");
        end

        // Source ignoring backpressure overflows the RX FIFO.
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = 8'(i);
            if (rxq.size() < 16) begin
                rxq.push_back(s_axis_tdata);
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        check("rx full tready", 32'(s_axis_tready), 32'd0);
        status_read("status overflow", 32'h0000_100D);
        cpu_write("clear overflow", REG_STATUS, 32'h0000_0004);
        status_read("status overflow cleared", 32'h0000_1009);
        for (int i = 0; i < 16; i++) begin
            data_read("rx drain");
        end
        data_read("rx drained empty");

        // Interrupt sources.
        cpu_write("ctrl rx irq", REG_CTRL, 32'h0000_0001);
        cpu_xfer("ctrl read", REG_CTRL, 4'h0, 32'h0, 1'b1, 32'h0000_0001);
        check("irq idle", 32'(irq), 32'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h5A;
        rxq.push_back(8'h5A);
        tick();
        s_axis_tvalid = 1'b0;
        check("irq lag", 32'(irq), 32'd0);
        tick();
        check("irq rx nonempty", 32'(irq), 32'd1);
        data_read("rx irq byte");
        check("irq after pop", 32'(irq), 32'd0);
        cpu_write("ctrl txe irq", REG_CTRL, 32'h0000_0002);
        check("irq tx empty", 32'(irq), 32'd1);

        // Reset during a stalled write abandons it and flushes the FIFOs.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_write("tx refill", REG_DATA, 32'(8'hA0 + i));
        end
        iomem_valid = 1'b1;
        iomem_addr  = BASE | 32'(REG_DATA);
        iomem_wstrb = 4'h1;
        iomem_wdata = 32'h0000_00EE;
        tick();
        tick();
        check("stall before reset", 32'(iomem_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("reset mid ready", 32'(iomem_ready), 32'd0);
        check("reset mid tvalid", 32'(m_axis_tvalid), 32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("irq after reset", 32'(irq), 32'd0);
        status_read("status after reset", 32'h0000_0008);
        check("tx scoreboard empty", 32'(txq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
